// File: rtl/proto_cmd_framer_pkg.sv
// Shared types and status encodings for the command framer.
package proto_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_COLLECT = 2'd2,
      ST_EMIT    = 2'd3
   } state_t;

   localparam logic [1:0] ST_IDLE_C  = 2'b00;
   localparam logic [1:0] ST_FRAME_C = 2'b01;
   localparam logic [1:0] ST_EMIT_C  = 2'b10;
   localparam logic [1:0] ST_LAST_C  = 2'b11;

endpackage

// File: rtl/proto_cmd_framer_timeout_ctr.sv
// Idle-cycle counter: expire is asserted in the TIMEOUT-th consecutive enabled cycle.
module proto_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_reg;

   assign expire = en && (cnt_reg == LAST_CNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (clr || expire) begin
         cnt_reg <= '0;
      end else if (en) begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: rtl/proto_cmd_framer.sv
// Frames a symbol stream into START / code / payload commands held on a valid-ready port,
// with idle timeout, abort symbol and a Mealy status output.
module proto_cmd_framer
   import proto_pkg::*;
#(
   parameter int SYM_W       = 2,
   parameter int PAYLOAD_LEN = 2,
   parameter int TIMEOUT     = 15,
   parameter int START_SYM   = 1,
   parameter int ABORT_SYM   = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sym_valid,
   input  logic [SYM_W-1:0]             sym,
   output logic                         sym_ready,
   output logic                         cmd_valid,
   input  logic                         cmd_ready,
   output logic [SYM_W-1:0]             cmd_code,
   output logic [PAYLOAD_LEN*SYM_W-1:0] cmd_payload,
   output logic                         err_timeout,
   output logic [1:0]                   status
);

   localparam int IW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
   localparam logic [SYM_W-1:0] START_V  = SYM_W'(START_SYM);
   localparam logic [SYM_W-1:0] ABORT_V  = SYM_W'(ABORT_SYM);
   localparam logic [IW-1:0]    LAST_IDX = IW'(PAYLOAD_LEN - 1);

   state_t           state_reg, state_next;
   logic [IW-1:0]    idx_reg;
   logic             cmd_valid_reg;
   logic [SYM_W-1:0] cmd_code_reg;
   logic             err_reg;

   logic acc, framing, last_acc, expire, ctr_en, ctr_clr;

   assign sym_ready = (state_reg != ST_EMIT);
   assign acc       = sym_valid & sym_ready;
   assign framing   = (state_reg == ST_ARMED) || (state_reg == ST_COLLECT);
   assign last_acc  = acc && (state_reg == ST_COLLECT) && (idx_reg == LAST_IDX);

   // Counter is held at zero outside framing, so entry to ARMED always starts it from zero.
   assign ctr_en  = framing & ~acc;
   assign ctr_clr = acc | ~framing;

   proto_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .en    (ctr_en),
      .clr   (ctr_clr),
      .expire(expire)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (acc && (sym == START_V)) state_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (expire) begin
               state_next = ST_IDLE;
            end else if (acc) begin
               if (sym == ABORT_V)      state_next = ST_IDLE;
               else if (sym != START_V) state_next = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (expire)        state_next = ST_IDLE;
            else if (last_acc) state_next = ST_EMIT;
         end
         ST_EMIT: begin
            if (cmd_valid_reg && cmd_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      status = ST_IDLE_C;
      case (state_reg)
         ST_ARMED:   status = ST_FRAME_C;
         ST_COLLECT: status = last_acc ? ST_LAST_C : ST_FRAME_C;
         ST_EMIT:    status = ST_EMIT_C;
         default:    status = ST_IDLE_C;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         idx_reg       <= '0;
         cmd_valid_reg <= 1'b0;
         cmd_code_reg  <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         err_reg   <= expire;
         case (state_reg)
            ST_ARMED: begin
               if (acc && (sym != ABORT_V) && (sym != START_V) && !expire) begin
                  cmd_code_reg <= sym;
                  idx_reg      <= '0;
               end
            end
            ST_COLLECT: begin
               if (last_acc) begin
                  idx_reg       <= '0;
                  cmd_valid_reg <= 1'b1;
               end else if (acc) begin
                  idx_reg <= idx_reg + IW'(1);
               end
            end
            ST_EMIT: begin
               if (cmd_ready) cmd_valid_reg <= 1'b0;
            end
            default: begin
               cmd_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   // One register per payload slot; slot 0 holds the first payload symbol received.
   genvar gi;
   generate
      for (gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_slot
         logic [SYM_W-1:0] slot_reg;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               slot_reg <= '0;
            end else if (acc && (state_reg == ST_COLLECT) && (idx_reg == IW'(gi))) begin
               slot_reg <= sym;
            end
         end
         assign cmd_payload[gi*SYM_W +: SYM_W] = slot_reg;
      end
   endgenerate

   assign cmd_valid   = cmd_valid_reg;
   assign cmd_code    = cmd_code_reg;
   assign err_timeout = err_reg;

endmodule

// File: tb/tb_proto_cmd_framer.sv
// Directed scenarios plus randomized traffic against a queue-based frame model.
module tb_proto_cmd_framer;

   localparam int SYM_W = 2;
   localparam int LEN   = 2;
   localparam int TO    = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic       sym_valid;
   logic [1:0] sym;
   logic       sym_ready;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_code;
   logic [3:0] cmd_payload;
   logic       err_timeout;
   logic [1:0] status;

   int checks = 0;
   int errors = 0;

   proto_cmd_framer #(
      .SYM_W(SYM_W), .PAYLOAD_LEN(LEN), .TIMEOUT(TO), .START_SYM(1), .ABORT_SYM(0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sym_valid  (sym_valid),
      .sym        (sym),
      .sym_ready  (sym_ready),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_code   (cmd_code),
      .cmd_payload(cmd_payload),
      .err_timeout(err_timeout),
      .status     (status)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [1:0] s, input logic r);
      sym_valid = v;
      sym       = s;
      cmd_ready = r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] s);
      drive(1'b1, s, 1'b1);
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 2'd0, 1'b0);
      tick();
      tick();
      #2 reset = 1'b0;
      #1;
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", cmd_valid); end
      checks++; if (cmd_code !== 2'd0) begin errors++; $display("FAIL reset_code got %0h want 0", cmd_code); end
      checks++; if (cmd_payload !== 4'd0) begin errors++; $display("FAIL reset_payload got %0h want 0", cmd_payload); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %0h want 0", err_timeout); end
      checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h want 1", sym_ready); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status got %0h want 0", status); end
      $display("reset: valid=%0h code=%0h payload=%0h status=%0h", cmd_valid, cmd_code, cmd_payload, status);
   endtask

   task automatic test_frame();
      logic [1:0] seq [4];
      logic [1:0] st_exp [4];
      seq    = '{2'd1, 2'd2, 2'd3, 2'd0};
      st_exp = '{2'b00, 2'b01, 2'b01, 2'b11};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, seq[i], 1'b1);
         checks++; if (status !== st_exp[i]) begin errors++; $display("FAIL frame_status[%0d] got %0h want %0h", i, status, st_exp[i]); end
         checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid[%0d] got %0h want 0", i, cmd_valid); end
         tick();
      end
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL frame_valid got %0h want 1", cmd_valid); end
      checks++; if (cmd_code !== 2'd2) begin errors++; $display("FAIL frame_code got %0h want 2", cmd_code); end
      checks++; if (cmd_payload !== 4'b0011) begin errors++; $display("FAIL frame_payload got %0h want 3", cmd_payload); end
      drive(1'b0, 2'd0, 1'b1);
      checks++; if (status !== 2'b10) begin errors++; $display("FAIL frame_emit_status got %0h want 2", status); end
      checks++; if (sym_ready !== 1'b0) begin errors++; $display("FAIL frame_emit_ready got %0h want 0", sym_ready); end
      tick();
      drive(1'b0, 2'd0, 1'b0);
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL frame_done_valid got %0h want 0", cmd_valid); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL frame_done_status got %0h want 0", status); end
      $display("frame: code=%0h payload=%0h back to idle status=%0h", cmd_code, cmd_payload, status);
   endtask

   task automatic test_backpressure();
      send(2'd1); send(2'd2); send(2'd3);
      drive(1'b1, 2'd0, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'd1, 1'b0);
         checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h want 1", i, cmd_valid); end
         checks++; if (cmd_code !== 2'd2) begin errors++; $display("FAIL bp_code[%0d] got %0h want 2", i, cmd_code); end
         checks++; if (cmd_payload !== 4'b0011) begin errors++; $display("FAIL bp_payload[%0d] got %0h want 3", i, cmd_payload); end
         checks++; if (sym_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %0h want 0", i, sym_ready); end
         tick();
      end
      drive(1'b1, 2'd1, 1'b1);
      tick();
      drive(1'b0, 2'd0, 1'b0);
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0h want 0", cmd_valid); end
      checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0h want 1", sym_ready); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL bp_release_status got %0h want 0", status); end
      $display("backpressure: held 5 cycles, released, status=%0h", status);
   endtask

   task automatic test_abort_rearm();
      send(2'd1); send(2'd1); send(2'd0);
      drive(1'b0, 2'd0, 1'b1);
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL abort_status got %0h want 0", status); end
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %0h want 0", cmd_valid); end
      send(2'd1); send(2'd1); send(2'd3); send(2'd2);
      drive(1'b1, 2'd2, 1'b1);
      checks++; if (status !== 2'b11) begin errors++; $display("FAIL rearm_last_status got %0h want 3", status); end
      tick();
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rearm_valid got %0h want 1", cmd_valid); end
      checks++; if (cmd_code !== 2'd3) begin errors++; $display("FAIL rearm_code got %0h want 3", cmd_code); end
      checks++; if (cmd_payload !== 4'b1010) begin errors++; $display("FAIL rearm_payload got %0h want a", cmd_payload); end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      $display("abort/rearm: code=3 payload=a frame consumed");
   endtask

   task automatic test_timeout();
      send(2'd1);
      for (int i = 1; i <= TO; i++) begin
         drive(1'b0, 2'd0, 1'b0);
         tick();
         if (i < TO) begin
            checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early_err[%0d] got %0h want 0", i, err_timeout); end
         end
      end
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err got %0h want 1", err_timeout); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL to_status got %0h want 0", status); end
      tick();
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %0h want 0", err_timeout); end
      send(2'd1);
      for (int i = 0; i < TO - 1; i++) begin
         drive(1'b0, 2'd0, 1'b0);
         tick();
      end
      send(2'd2);
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_save_err got %0h want 0", err_timeout); end
      drive(1'b1, 2'd1, 1'b1);
      checks++; if (status !== 2'b01) begin errors++; $display("FAIL to_save_status got %0h want 1", status); end
      tick();
      drive(1'b1, 2'd2, 1'b1);
      checks++; if (status !== 2'b11) begin errors++; $display("FAIL to_collect_last got %0h want 3", status); end
      tick();
      checks++; if (cmd_code !== 2'd2) begin errors++; $display("FAIL to_code got %0h want 2", cmd_code); end
      checks++; if (cmd_payload !== 4'b1001) begin errors++; $display("FAIL to_payload got %0h want 9", cmd_payload); end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      $display("timeout: abort after %0d idle cycles, last-cycle accept wins", TO);
   endtask

   task automatic test_idle_noise();
      logic [1:0] noise [3];
      noise = '{2'd0, 2'd2, 2'd3};
      for (int i = 0; i < 3; i++) begin
         send(noise[i]);
         drive(1'b0, 2'd0, 1'b0);
         checks++; if (status !== 2'b00) begin errors++; $display("FAIL noise_status[%0d] got %0h want 0", i, status); end
         checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL noise_valid[%0d] got %0h want 0", i, cmd_valid); end
         checks++; if (cmd_code !== 2'd2) begin errors++; $display("FAIL noise_code[%0d] got %0h want 2", i, cmd_code); end
      end
      send(2'd1);
      drive(1'b0, 2'd0, 1'b0);
      checks++; if (status !== 2'b01) begin errors++; $display("FAIL noise_armed got %0h want 1", status); end
      send(2'd0);
      $display("idle noise: ignored 0,2,3 then armed on 1");
   endtask

   task automatic test_reset_mid();
      send(2'd1); send(2'd2); send(2'd3);
      drive(1'b0, 2'd0, 1'b0);
      #2 reset = 1'b1;
      #1;
      checks++; if (cmd_code !== 2'd0) begin errors++; $display("FAIL rstmid_code got %0h want 0", cmd_code); end
      checks++; if (cmd_payload !== 4'd0) begin errors++; $display("FAIL rstmid_payload got %0h want 0", cmd_payload); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL rstmid_status got %0h want 0", status); end
      tick();
      #2 reset = 1'b0;
      send(2'd1); send(2'd3); send(2'd1); send(2'd1);
      checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got %0h want 1", cmd_valid); end
      checks++; if (cmd_code !== 2'd3) begin errors++; $display("FAIL rstmid_next_code got %0h want 3", cmd_code); end
      checks++; if (cmd_payload !== 4'b0101) begin errors++; $display("FAIL rstmid_next_payload got %0h want 5", cmd_payload); end
      drive(1'b0, 2'd0, 1'b1);
      tick();
      $display("reset mid-collect: cleared, next frame code=3 payload=5");
   endtask

   task automatic test_random();
      bit          m_arm, m_emit, m_err, acc, v, r;
      logic [1:0]  q[$];
      logic [1:0]  m_code, s, exp_status;
      logic [3:0]  m_pay;
      int          m_idle, frames;
      int unsigned mode;
      reset = 1'b1;
      drive(1'b0, 2'd0, 1'b0);
      tick();
      #2 reset = 1'b0;
      m_arm = 0; m_emit = 0; m_err = 0; m_idle = 0; frames = 0;
      m_code = '0; m_pay = '0; q.delete(); mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 32 == 0) mode = $urandom_range(0, 4);
         v = (mode == 0) ? 1'b0 : ($urandom_range(0, 3) < mode);
         s = 2'($urandom_range(0, 3));
         r = ($urandom_range(0, 2) != 0);
         drive(v, s, r);
         acc = v && !m_emit;
         exp_status = m_emit ? 2'b10 : !m_arm ? 2'b00 : (acc && q.size() == LEN) ? 2'b11 : 2'b01;
         checks++; if (status !== exp_status) begin errors++; $display("FAIL rnd_status@%0d got %0h want %0h", c, status, exp_status); end
         checks++; if (sym_ready !== !m_emit) begin errors++; $display("FAIL rnd_ready@%0d got %0h want %0h", c, sym_ready, !m_emit); end
         checks++; if (cmd_valid !== m_emit) begin errors++; $display("FAIL rnd_valid@%0d got %0h want %0h", c, cmd_valid, m_emit); end
         checks++; if (err_timeout !== m_err) begin errors++; $display("FAIL rnd_err@%0d got %0h want %0h", c, err_timeout, m_err); end
         if (m_emit) begin
            checks++; if (cmd_code !== m_code) begin errors++; $display("FAIL rnd_code@%0d got %0h want %0h", c, cmd_code, m_code); end
            checks++; if (cmd_payload !== m_pay) begin errors++; $display("FAIL rnd_payload@%0d got %0h want %0h", c, cmd_payload, m_pay); end
         end
         tick();
         m_err = 0;
         if (m_emit) begin
            if (r) m_emit = 0;
         end else if (m_arm) begin
            if (acc) begin
               m_idle = 0;
               if (q.size() == 0 && s == 2'd0) begin
                  m_arm = 0;
               end else if (!(q.size() == 0 && s == 2'd1)) begin
                  q.push_back(s);
                  if (q.size() == LEN + 1) begin
                     m_code = q[0];
                     for (int k = 0; k < LEN; k++) m_pay[k*SYM_W +: SYM_W] = q[k+1];
                     q.delete();
                     m_arm  = 0;
                     m_emit = 1;
                     frames++;
                  end
               end
            end else begin
               m_idle++;
               if (m_idle == TO) begin
                  m_arm = 0; m_err = 1; m_idle = 0;
                  q.delete();
               end
            end
         end else if (acc && s == 2'd1) begin
            m_arm = 1; m_idle = 0;
         end
      end
      $display("random: 3000 cycles, %0d frames modelled", frames);
   endtask

   initial begin
      reset = 1'b0;
      sym_valid = 1'b0; sym = 2'd0; cmd_ready = 1'b0;
      test_reset();
      test_frame();
      test_backpressure();
      test_abort_rearm();
      test_timeout();
      test_idle_noise();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
